// File: rtl/sseg_rom_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_rom_scan_ctrl
//
// Purpose:
//   Multiplexed N-digit seven-segment scan controller. One synchronous pattern
//   ROM is shared by all digits. Each digit slot has two parts. First the
//   controller fetches the pattern for that digit's hex nibble, which takes
//   three cycles with every anode off. Then it drives that digit's anode for
//   DWELL_CYC cycles. This block sits between the datapath that produces
//   hex_in and the board's an/sseg pins.
//
//   Slot timeline, counted in rising edges from the edge that samples hex_in:
//     edge 1  (S_ADDR) : rom_addr <= nibble of digit idx
//     edge 2  (S_WAIT) : the external ROM registers rom_addr
//     edge 3  (S_CAP)  : sseg/an updated, dwell counter loaded
//     edges 4..DWELL_CYC+3 (S_SHOW) : the final edge blanks an and advances idx
//   The anode is low for exactly DWELL_CYC cycles. A slot is DWELL_CYC+3
//   cycles long.
//
// Parameters:
//   N_DIG      number of digits scanned (1..8)
//   DWELL_CYC  display cycles per digit slot (>= 1)
//
// Ports:
//   clk         in   1        system clock, all state on rising edge
//   reset       in   1        asynchronous, active-high reset
//   en          in   1        scan enable, looked at only between slots
//   hex_in      in   4*N_DIG  digit i nibble = hex_in[4i+3:4i], digit 0 rightmost
//   dp_in       in   N_DIG    decimal point per digit, active-high
//   blank       in   N_DIG    per-digit blank, active-high, keeps that anode off
//   rom_addr    out  4        registered ROM address
//   rom_data    in   8        ROM pattern, [6:0] active-low segments {a..g}, [7] unused
//   an          out  N_DIG    registered anodes, active-low, at most one low
//   sseg        out  8        registered {dp_n, seg[6:0]}, active-low
//   frame_tick  out  1        one-cycle pulse when the last digit's slot ends
// ---------------------------------------------------------------------------
module sseg_rom_scan_ctrl #(
    parameter int N_DIG     = 4,
    parameter int DWELL_CYC = 100_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [4*N_DIG-1:0]   hex_in,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blank,
    output logic [3:0]           rom_addr,
    input  logic [7:0]           rom_data,
    output logic [N_DIG-1:0]     an,
    output logic [7:0]           sseg,
    output logic                 frame_tick
);

    // -----------------------------------------------------------------------
    // Local constants and types
    // -----------------------------------------------------------------------
    localparam int CNT_W = $clog2(DWELL_CYC + 1);
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    // The counter is loaded with DWELL_CYC-1 and the slot ends on the edge
    // where it reads zero. That gives DWELL_CYC cycles in S_SHOW.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [N_DIG-1:0] AN_OFF   = '1;
    localparam logic [7:0]       SSEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,   // waiting for en, then issue the ROM address
        S_WAIT = 2'd1,   // ROM registers the address on this edge
        S_CAP  = 2'd2,   // ROM data valid: latch pattern and drive the anode
        S_SHOW = 2'd3    // dwell with the anode on
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           rom_addr_q, rom_addr_d;
    logic [N_DIG-1:0]     an_q, an_d;
    logic [7:0]           sseg_q, sseg_d;
    logic                 frame_tick_q, frame_tick_d;

    // -----------------------------------------------------------------------
    // Helper terms
    // -----------------------------------------------------------------------
    logic [3:0] cur_nibble;
    logic       cnt_zero;
    logic       idx_is_last;

    // {idx, 2'b00} is 4*idx. It has just enough bits to address every
    // nibble of hex_in.
    assign cur_nibble  = hex_in[{idx_q, 2'b00} +: 4];
    assign cnt_zero    = (cnt_q == '0);
    assign idx_is_last = (idx_q == IDX_LAST);

    // Bit 7 of the ROM word carries no meaning for this block.
    logic rom_data_unused;
    assign rom_data_unused = rom_data[7];

    // -----------------------------------------------------------------------
    // Process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever order the
    // assignments are written in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_ADDR;
            idx_q        <= IDX_ZERO;
            cnt_q        <= '0;
            rom_addr_q   <= 4'h0;
            an_q         <= AN_OFF;
            sseg_q       <= SSEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // -----------------------------------------------------------------------
    // Process 2: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable written in a combinational block gets a default at
    // the top. A path that skips an assignment then cannot infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_ADDR: if (en) state_d = S_WAIT;
            S_WAIT: state_d = S_CAP;
            S_CAP:  state_d = S_SHOW;
            S_SHOW: if (cnt_zero) state_d = S_ADDR;
            default: state_d = S_ADDR;
        endcase
    end

    // -----------------------------------------------------------------------
    // Process 3: registered-output and datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        // Everything holds unless this state updates it. frame_tick is a
        // pulse, so it clears by default.
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        an_d         = an_q;
        sseg_d       = sseg_q;
        frame_tick_d = 1'b0;

        unique case (state_q)
            S_ADDR: begin
                // While en is low the FSM parks here. The anodes stay off
                // because the previous slot ended with them blanked.
                if (en) rom_addr_d = cur_nibble;
            end

            S_WAIT: begin
                // Nothing to do. The external ROM is capturing rom_addr.
            end

            S_CAP: begin
                // The ROM pattern goes straight to the segment pins. Only the
                // decimal point is added here.
                sseg_d = {~dp_in[idx_q], rom_data[6:0]};
                an_d   = AN_OFF;
                if (!blank[idx_q]) an_d[idx_q] = 1'b0;
                cnt_d  = CNT_LOAD;
            end

            S_SHOW: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // The anode is turned off here and stays off through the
                    // next fetch. This stops the old pattern from ghosting
                    // onto the next digit. sseg keeps its value, because an
                    // alone controls visibility.
                    an_d         = AN_OFF;
                    idx_d        = idx_is_last ? IDX_ZERO : idx_q + IDX_W'(1);
                    frame_tick_d = idx_is_last;
                end
            end

            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs come directly from flops
    // -----------------------------------------------------------------------
    assign rom_addr   = rom_addr_q;
    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule
